// File: rtl/memory_monitor_hyst.sv
// Pile-up occupancy monitor for one OFC event-memory bank: counts accepted-but-unread
// events and drives back-pressure with stop/resume hysteresis. Define PILEUP_STATS_EN for peak/stop statistics.
module memory_monitor_hyst #(
  parameter int CNT_W         = 6,
  parameter int MAX_NEVENT    = 46,
  parameter int RESUME_NEVENT = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             live_rising,
  input  logic             trig_accepted,
  input  logic             read_complete,
  output logic [CNT_W-1:0] n_pileup,
  output logic             stop,
  output logic             read_overflow,
  output logic             trig_overflow,
  output logic             running
`ifdef PILEUP_STATS_EN
  ,
  output logic [CNT_W-1:0] peak_pileup,
  output logic [15:0]      n_stop_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_FULL   = '1;
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_NEVENT);
  localparam logic [CNT_W-1:0] RESUME_CNT = CNT_W'(RESUME_NEVENT);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt_n;
  logic             rovf_n, tovf_n;

  // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
  always_comb begin
    state_n = state;
    cnt_n   = n_pileup;
    rovf_n  = read_overflow;
    tovf_n  = trig_overflow;
    if (live_rising) begin
      state_n = RUN;
      cnt_n   = '0;
      rovf_n  = 1'b0;
      tovf_n  = 1'b0;
    end else if (state != IDLE) begin
      // A trigger and a readout in the same cycle cancel, even at the counter limits.
      case ({trig_accepted, read_complete})
        2'b10: begin
          if (n_pileup == CNT_FULL) tovf_n = 1'b1;
          else                      cnt_n  = n_pileup + CNT_W'(1);
        end
        2'b01: begin
          if (n_pileup == '0) rovf_n = 1'b1;
          else                cnt_n  = n_pileup - CNT_W'(1);
        end
        default: ;
      endcase
      if (state == RUN && cnt_n >= MAX_CNT)
        state_n = HOLD;
      else if (state == HOLD && cnt_n <= RESUME_CNT)
        state_n = RUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      n_pileup      <= '0;
      stop          <= 1'b0;
      read_overflow <= 1'b0;
      trig_overflow <= 1'b0;
    end else begin
      state         <= state_n;
      n_pileup      <= cnt_n;
      stop          <= (state_n == HOLD);
      read_overflow <= rovf_n;
      trig_overflow <= tovf_n;
    end
  end

  assign running = (state != IDLE);

`ifdef PILEUP_STATS_EN
  // Statistics follow the live period: cleared by live_rising, peak tracks the new count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_pileup   <= '0;
      n_stop_cycles <= '0;
    end else if (live_rising) begin
      peak_pileup   <= '0;
      n_stop_cycles <= '0;
    end else begin
      if (cnt_n > peak_pileup) peak_pileup <= cnt_n;
      if (stop && n_stop_cycles != 16'hFFFF) n_stop_cycles <= n_stop_cycles + 16'd1;
    end
  end
`endif

endmodule
